piso_serializer: RTL

//  Parallel-in serial-out shift register. It is the transmit end for the 10-bit sipo receiver.
//  - Accepts a WIDTH-bit word through a valid/ready handshake.
//  - Shifts the word out one bit per clk rising edge.
//  - Flags the first and last bit of each frame.
//  - Words sent back to back produce a gap-free serial stream that a sipo can capture directly.

---
 rtl/piso_pkg.sv | 16 +
 rtl/piso_serializer_if.sv | 26 ++
 rtl/piso_bit_counter.sv | 28 ++
 rtl/piso_serializer.sv | 115 +++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the PISO serializer.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int WIDTH_DEF = 10;

    // Counter width able to hold 0..width inclusive.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel-word handshake in, framed serial stream out.
interface piso_serializer_if #(
    parameter int WIDTH = piso_pkg::WIDTH_DEF
) ();

    logic [WIDTH-1:0] parallel_in;
    logic             in_valid;
    logic             in_ready;
    logic             serial_out;
    logic             out_valid;
    logic             frame_start;
    logic             frame_last;

    // Word source / stream sink side.
    modport master (
        output parallel_in, in_valid,
        input  in_ready, serial_out, out_valid, frame_start, frame_last
    );

    // Serializer side.
    modport slave (
        input  parallel_in, in_valid,
        output in_ready, serial_out, out_valid, frame_start, frame_last
    );

endinterface

// File: rtl/piso_bit_counter.sv
// Frame bit counter: clear, load-to-1, saturating increment, last-bit flag.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = cnt_w(WIDTH)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          load,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          at_last
);

    assign at_last = (cnt == CW'(WIDTH));

    // Clear wins, then load, then increment; never counts past WIDTH.
    always_ff @(posedge clk) begin
        if (clr)
            cnt <= '0;
        else if (load)
            cnt <= CW'(1);
        else if (inc && !at_last)
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with frame start/last flags.
// Back-to-back words stream without an idle cycle between frames.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reinicio,
    piso_serializer_if.slave bus
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    bit_cnt;
    logic             at_last;
    logic             accept;
    logic             load, inc, clr_fsm;
    logic             first_bit, next_bit;
    logic [WIDTH-1:0] load_rest, shifted;
    logic             so_q, ov_q, fs_q, fl_q;

    // Ready while idle, or while the last bit of a frame is on the line.
    assign bus.in_ready = (state == IDLE) || at_last;
    assign accept       = bus.in_valid && bus.in_ready;

    // The first bit leaves straight from parallel_in, so the register keeps
    // the word already advanced by one position.
    assign first_bit = MSB_FIRST ? bus.parallel_in[WIDTH-1] : bus.parallel_in[0];
    assign load_rest = MSB_FIRST ? (bus.parallel_in << 1) : (bus.parallel_in >> 1);
    assign next_bit  = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
    assign shifted   = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);

    piso_bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
        .clk     (clk),
        .clr     (reinicio | clr_fsm),
        .load    (load),
        .inc     (inc),
        .cnt     (bit_cnt),
        .at_last (at_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reinicio)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and datapath controls.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        inc       = 1'b0;
        clr_fsm   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    load      = 1'b1;
                end
            end
            SHIFT: begin
                if (!at_last) begin
                    inc = 1'b1;
                end else if (accept) begin
                    load = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    clr_fsm   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register and registered outputs; everything is 0 when not valid.
    always_ff @(posedge clk) begin
        if (reinicio) begin
            shift_reg <= '0;
            so_q      <= 1'b0;
            ov_q      <= 1'b0;
            fs_q      <= 1'b0;
            fl_q      <= 1'b0;
        end else if (load) begin
            shift_reg <= load_rest;
            so_q      <= first_bit;
            ov_q      <= 1'b1;
            fs_q      <= 1'b1;
            fl_q      <= (WIDTH == 1);
        end else if (inc) begin
            shift_reg <= shifted;
            so_q      <= next_bit;
            ov_q      <= 1'b1;
            fs_q      <= 1'b0;
            fl_q      <= (bit_cnt == CW'(WIDTH - 1));
        end else begin
            shift_reg <= '0;
            so_q      <= 1'b0;
            ov_q      <= 1'b0;
            fs_q      <= 1'b0;
            fl_q      <= 1'b0;
        end
    end

    assign bus.serial_out  = so_q;
    assign bus.out_valid   = ov_q;
    assign bus.frame_start = fs_q;
    assign bus.frame_last  = fl_q;

endmodule
